snake_body: RTL and testbench

Snake body tracker, sitting directly downstream of the head-box mover. It watches the head box's top-left corner, records the head's previous positions in a shift buffer, and answers one question per pixel: "is the current VGA scan position inside a body segment?" It also flags when the head lands on its own body. Its outputs feed the pixel colour mux and the game-over logic.

---
 rtl/snake_body.sv | 141 ++++++++++++++
 tb/tb_snake_body.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body.sv
// snake_body: tracks the snake's body as a shift buffer of past head positions,
// answers per-pixel "inside a body segment?" with a one-cycle registered result,
// and optionally flags the head landing on its own body.
// Optional feature macro: SNAKE_SELF_HIT_EN (self-hit compare and sticky collide flag).
module snake_body #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int SEG      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] head_l,
    input  logic [9:0] head_u,
    input  logic       grow,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    output logic       body_on,
    output logic       collide,
    output logic [4:0] length
);
    localparam logic [4:0]  MAX_LEN_C  = 5'(MAX_LEN);
    localparam logic [4:0]  INIT_LEN_C = 5'(INIT_LEN);
    localparam logic [10:0] SEG_C      = 11'(SEG);

    // Increment that sticks at the limit.
    function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic [4:0] lim);
        return (v < lim) ? v + 5'd1 : lim;
    endfunction

    // Clamp a 6-bit count down to a 5-bit limit.
    function automatic logic [4:0] sat_min(input logic [5:0] v, input logic [4:0] lim);
        return (v > {1'b0, lim}) ? lim : v[4:0];
    endfunction

    // True when pos lies in [base, base+SEG); 11-bit sum so the edge never wraps.
    function automatic logic in_span(input logic [9:0] base, input logic [9:0] pos);
        return ({1'b0, pos} >= {1'b0, base}) && ({1'b0, pos} < ({1'b0, base} + SEG_C));
    endfunction

    logic [9:0] seg_l_q [MAX_LEN];
    logic [9:0] seg_u_q [MAX_LEN];
    logic [9:0] prev_l_q, prev_u_q;
    logic       primed_q;
    logic [4:0] filled_q, filled_d;
    logic [4:0] length_q, length_d;
    logic       pend_grow_q, pend_grow_d;
    logic       body_on_q;
    logic       move;
    logic       pix_hit;

    // Head movement is any change from last cycle's head once history is primed.
    always_comb begin
        move        = primed_q && ((head_l != prev_l_q) || (head_u != prev_u_q));
        length_d    = (move && pend_grow_q) ? sat_inc(length_q, MAX_LEN_C) : length_q;
        filled_d    = move ? sat_min({1'b0, filled_q} + 6'd1, length_d) : filled_q;
        // A grow seen on a move cycle re-arms for the next move; at full length it is dropped.
        if (grow && (length_q < MAX_LEN_C)) begin
            pend_grow_d = 1'b1;
        end else if (move) begin
            pend_grow_d = 1'b0;
        end else begin
            pend_grow_d = pend_grow_q;
        end
    end

    // OR together every live segment that contains the current scan position.
    always_comb begin
        pix_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((5'(i) < filled_q) && in_span(seg_l_q[i], hcount) && in_span(seg_u_q[i], vcount)) begin
                pix_hit = 1'b1;
            end
        end
    end

    // Control state: priming, fill count, length, pending grow and the pixel result.
    always_ff @(posedge clk) begin
        if (rst) begin
            primed_q    <= 1'b0;
            filled_q    <= 5'd0;
            length_q    <= INIT_LEN_C;
            pend_grow_q <= 1'b0;
            body_on_q   <= 1'b0;
        end else begin
            primed_q    <= 1'b1;
            filled_q    <= filled_d;
            length_q    <= length_d;
            pend_grow_q <= pend_grow_d;
            body_on_q   <= pix_hit;
        end
    end

    // Position history: prev follows the head every cycle; segments shift on a move.
    always_ff @(posedge clk) begin
        prev_l_q <= head_l;
        prev_u_q <= head_u;
        if (move && !rst) begin
            seg_l_q[0] <= prev_l_q;
            seg_u_q[0] <= prev_u_q;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_l_q[i] <= seg_l_q[i-1];
                seg_u_q[i] <= seg_u_q[i-1];
            end
        end
    end

`ifdef SNAKE_SELF_HIT_EN
    logic chk_q;
    logic collide_q;
    logic head_hit;

    // The head matches a live segment exactly (segments are grid aligned with the head).
    always_comb begin
        head_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((5'(i) < filled_q) && (seg_l_q[i] == head_l) && (seg_u_q[i] == head_u)) begin
                head_hit = 1'b1;
            end
        end
    end

    // Compare once, the cycle after each shift; collide is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q     <= 1'b0;
            collide_q <= 1'b0;
        end else begin
            chk_q     <= move;
            collide_q <= collide_q | (chk_q & head_hit);
        end
    end

    assign collide = collide_q;
`else
    assign collide = 1'b0;
`endif

    assign body_on = body_on_q;
    assign length  = length_q;

endmodule

// File: tb/tb_snake_body.sv
// Self-checking bench for snake_body: directed scenarios plus a randomized walk
// checked against a queue-based model of the snake's position history.
module tb_snake_body;
    localparam int SEG      = 10;
    localparam int MAX_LEN  = 16;
    localparam int INIT_LEN = 3;
`ifdef SNAKE_SELF_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] head_l, head_u, hcount, vcount;
    logic       grow;
    logic       body_on, collide;
    logic [4:0] length;

    int errors = 0;
    int checks = 0;

    snake_body #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .SEG(SEG)) dut (
        .clk(clk), .rst(rst), .head_l(head_l), .head_u(head_u), .grow(grow),
        .hcount(hcount), .vcount(vcount), .body_on(body_on), .collide(collide),
        .length(length)
    );

    always #5 clk = ~clk;

    // Model: most recent previous head first, truncated to the current length.
    int ql[$];
    int qu[$];
    int m_len = INIT_LEN;
    int m_pl = 0, m_pu = 0;
    bit m_pend = 0, m_primed = 0, m_chk = 0, m_coll = 0, m_body = 0;

    function automatic bit m_pix(int x, int y);
        for (int k = 0; k < ql.size(); k++)
            if (x >= ql[k] && x < ql[k] + SEG && y >= qu[k] && y < qu[k] + SEG) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_on_body(int x, int y);
        for (int k = 0; k < ql.size(); k++)
            if (x == ql[k] && y == qu[k]) return 1'b1;
        return 1'b0;
    endfunction

    // Advance model and DUT by one clock edge with the inputs currently driven.
    task automatic step();
        bit nb, mv;
        nb = m_pix(int'(hcount), int'(vcount));
        if (rst) begin
            ql.delete(); qu.delete();
            m_len = INIT_LEN; m_pend = 0; m_primed = 0; m_chk = 0; m_coll = 0; m_body = 0;
        end else begin
            if (HIT_EN && m_chk && m_on_body(int'(head_l), int'(head_u))) m_coll = 1;
            mv = m_primed && (int'(head_l) != m_pl || int'(head_u) != m_pu);
            if (mv) begin
                ql.push_front(m_pl);
                qu.push_front(m_pu);
                if (m_pend) begin
                    if (m_len < MAX_LEN) m_len++;
                    m_pend = 0;
                end
                while (ql.size() > m_len) begin
                    void'(ql.pop_back());
                    void'(qu.pop_back());
                end
            end
            if (grow && m_len < MAX_LEN) m_pend = 1;
            m_chk = mv;
            m_primed = 1;
            m_body = nb;
        end
        m_pl = int'(head_l);
        m_pu = int'(head_u);
        @(posedge clk);
        #1;
    endtask

    task automatic move_to(int l, int u);
        head_l = 10'(l);
        head_u = 10'(u);
        step(); step(); step();
    endtask

    task automatic scan(int x, int y);
        hcount = 10'(x);
        vcount = 10'(y);
        step();
    endtask

    task automatic do_reset(int l, int u);
        rst = 1'b1; grow = 1'b0;
        head_l = 10'(l); head_u = 10'(u);
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        hcount = 10'd154; vcount = 10'd45;
        do_reset(154, 45);
        checks++; if (body_on !== 1'b0) begin errors++; $display("FAIL reset_body_on got=%b want=0", body_on); end
        checks++; if (collide !== 1'b0) begin errors++; $display("FAIL reset_collide got=%b want=0", collide); end
        checks++; if (length !== 5'd3) begin errors++; $display("FAIL reset_length got=%0d want=3", length); end
        step();               // priming cycle
        scan(154, 45);
        scan(154, 45);
        checks++; if (body_on !== 1'b0) begin errors++; $display("FAIL priming_no_shift got=%b want=0", body_on); end
    endtask

    task automatic test_first_move();
        int xs[4] = '{154, 163, 164, 153};
        int ys[4] = '{45, 54, 45, 45};
        bit ex[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        move_to(164, 45);
        for (int k = 0; k < 4; k++) begin
            scan(xs[k], ys[k]);
            checks++;
            if (body_on !== ex[k]) begin
                errors++; $display("FAIL first_move_scan(%0d,%0d) got=%b want=%b", xs[k], ys[k], body_on, ex[k]);
            end
        end
        checks++; if (length !== 5'd3) begin errors++; $display("FAIL first_move_length got=%0d want=3", length); end
    endtask

    task automatic test_tail_expiry();
        int xs[6] = '{174, 184, 194, 154, 164, 204};
        bit ex[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 1; k <= 4; k++) move_to(164 + 10 * k, 45);
        for (int k = 0; k < 6; k++) begin
            scan(xs[k] + 3, 48);
            checks++;
            if (body_on !== ex[k]) begin
                errors++; $display("FAIL tail_expiry_L%0d got=%b want=%b", xs[k], body_on, ex[k]);
            end
        end
    endtask

    task automatic test_grow();
        grow = 1'b1; step(); grow = 1'b0; step();
        move_to(214, 45);
        checks++; if (length !== 5'd4) begin errors++; $display("FAIL grow_length got=%0d want=4", length); end
        for (int k = 0; k < 5; k++) begin
            scan(164 + 10 * k, 50);
            checks++;
            if (body_on !== (k != 0)) begin
                errors++; $display("FAIL grow_lit_L%0d got=%b want=%b", 164 + 10 * k, body_on, (k != 0));
            end
        end
        // grow on the same edge as a move only lands at the following move
        grow = 1'b1; head_l = 10'd224; step(); grow = 1'b0; step(); step();
        checks++; if (length !== 5'd4) begin errors++; $display("FAIL grow_same_cycle got=%0d want=4", length); end
        move_to(234, 45);
        checks++; if (length !== 5'd5) begin errors++; $display("FAIL grow_deferred got=%0d want=5", length); end
    endtask

    task automatic test_self_hit();
        do_reset(154, 45);
        step();
        grow = 1'b1; step(); grow = 1'b0; step();
        move_to(164, 45);
        move_to(164, 55);
        move_to(154, 55);
        head_l = 10'd154; head_u = 10'd45;
        step();               // shift edge
        checks++; if (collide !== 1'b0) begin errors++; $display("FAIL self_hit_early got=%b want=0", collide); end
        checks++; if (length !== 5'd4) begin errors++; $display("FAIL self_hit_length got=%0d want=4", length); end
        step();               // compare edge
        checks++; if (collide !== HIT_EN) begin errors++; $display("FAIL self_hit_rise got=%b want=%b", collide, HIT_EN); end
        for (int k = 0; k < 4; k++) step();
        checks++; if (collide !== HIT_EN) begin errors++; $display("FAIL self_hit_sticky got=%b want=%b", collide, HIT_EN); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (collide !== 1'b0) begin errors++; $display("FAIL self_hit_reset got=%b want=0", collide); end
    endtask

    task automatic test_saturation();
        int xs[4] = '{244, 94, 84, 254};
        bit ex[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset(4, 100);
        step();
        for (int n = 1; n <= 20; n++) begin
            grow = 1'b1; step(); grow = 1'b0;
            head_l = 10'(4 + 10 * n); step(); step(); step();
        end
        checks++; if (length !== 5'd16) begin errors++; $display("FAIL saturation_length got=%0d want=16", length); end
        for (int n = 21; n <= 25; n++) begin
            grow = 1'b1; step(); grow = 1'b0;
            head_l = 10'(4 + 10 * n); step(); step(); step();
        end
        checks++; if (length !== 5'd16) begin errors++; $display("FAIL saturation_hold got=%0d want=16", length); end
        for (int k = 0; k < 4; k++) begin
            scan(xs[k] + 5, 105);
            checks++;
            if (body_on !== ex[k]) begin
                errors++; $display("FAIL saturation_L%0d got=%b want=%b", xs[k], body_on, ex[k]);
            end
        end
    endtask

    task automatic test_random();
        int hl = 300, hu = 240, cd = 4, d, dl, du, x, y, k;
        do_reset(hl, hu);
        for (int c = 0; c < 700; c++) begin
            if (ql.size() > 0 && $urandom_range(1, 0) == 1) begin
                k = $urandom_range(ql.size() - 1, 0);
                x = ql[k] + $urandom_range(13, 0) - 2;
                y = qu[k] + $urandom_range(13, 0) - 2;
            end else begin
                x = hl + $urandom_range(40, 0) - 15;
                y = hu + $urandom_range(40, 0) - 15;
            end
            hcount = 10'(x); vcount = 10'(y);
            grow = ($urandom_range(7, 0) == 0);
            cd--;
            if (cd == 0) begin
                d = $urandom_range(3, 0);
                dl = (d == 0) ? SEG : (d == 1) ? -SEG : 0;
                du = (d == 2) ? SEG : (d == 3) ? -SEG : 0;
                if (hl + dl < 100 || hl + dl > 500) dl = -dl;
                if (hu + du < 100 || hu + du > 500) du = -du;
                hl += dl; hu += du;
                head_l = 10'(hl); head_u = 10'(hu);
                cd = $urandom_range(6, 3);
            end
            step();
            checks++;
            if (body_on !== m_body) begin errors++; $display("FAIL rand_body_on cyc=%0d got=%b want=%b", c, body_on, m_body); end
            checks++;
            if (collide !== m_coll) begin errors++; $display("FAIL rand_collide cyc=%0d got=%b want=%b", c, collide, m_coll); end
            checks++;
            if (int'(length) != m_len) begin errors++; $display("FAIL rand_length cyc=%0d got=%0d want=%0d", c, length, m_len); end
        end
        grow = 1'b0;
    endtask

    initial begin
        rst = 1'b1; grow = 1'b0;
        head_l = 10'd154; head_u = 10'd45; hcount = 10'd0; vcount = 10'd0;
        test_reset();
        test_first_move();
        test_tail_expiry();
        test_grow();
        test_self_hit();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
